fsm_counter: RTL and testbench
==============================

# fsm_counter

Parametrised successor to the 2-bit enable counter FSM. It is a WIDTH-bit modulo-MODULUS state counter with up/down direction, synchronous parallel load, wrap or saturate mode, a combinational terminal-count flag and a registered overflow pulse. It is intended as the general sequencing counter for later FSM examples and their benches.

## Interface
- WIDTH, 4, width of the state register; legal range 1..16
- MODULUS, 10, number of states (0..MODULUS-1); legal range 2..2**WIDTH
- SATURATE, 0, end-of-range mode: 0 = wrap around, 1 = hold at the end of range
- clk  input  1  single clock; all state changes occur on its rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising clk
- E  input  1  count enable
- U  input  1  direction: 1 = up, 0 = down
- L  input  1  synchronous load strobe
- D  input  WIDTH  load value
- S  output  WIDTH  current state (registered)
- TC  output  1  terminal count (combinational)
- OV  output  1  overflow/underflow pulse (registered)

## Operation
- Priority at each rising clk: reset low > L high > E high > hold.
- reset low: S <= 0, OV <= 0.
- L high: S <= D if D < MODULUS, else S <= MODULUS-1 (clamp). OV <= 0. E and U are ignored.
- E high, U high:
  - S < MODULUS-1: S <= S+1.
  - S == MODULUS-1, SATURATE=0: S <= 0, OV <= 1.
  - S == MODULUS-1, SATURATE=1: S holds, OV <= 1.
- E high, U low:
  - S > 0: S <= S-1.
  - S == 0, SATURATE=0: S <= MODULUS-1, OV <= 1.
  - S == 0, SATURATE=1: S holds, OV <= 1.
- E low (no load, reset high): S holds, OV <= 0.
- TC = E & ((U & S == MODULUS-1) | (~U & S == 0)). TC is high exactly when the next enabled edge will cross or hit the range end.
- All comparisons are unsigned WIDTH-bit. MODULUS-1 is computed at elaboration. MODULUS == 2**WIDTH must not overflow the comparison constant.
- S never leaves 0..MODULUS-1 after the first reset.

## Timing
- Reset values: S = 0, OV = 0. TC = 0 after reset while E is low.
- Latency: S changes one clk after E, L or reset is sampled. A sampled input is visible on S after the rising edge.
- OV is high for exactly one cycle, following the edge that wrapped or was blocked.
  - With E held high in saturate mode at the end of range, OV stays high every cycle. Each edge is a new blocked event.
- TC is combinational from S, E and U. There is no added latency. In wrap mode TC is high in the cycle before OV.
- Simultaneous events:
  - L with E at the end of range: the load wins and OV = 0.
  - reset low with L or E: reset wins.
- Reset mid-count: S = 0 on the next edge regardless of direction. An OV pending from the prior cycle is cleared on that same edge.
- Direction change takes effect on the next enabled edge. No dead cycle is inserted.
- Reset is synchronous only. Asserting reset between edges has no effect until the next rising clk.

## Test plan
- WIDTH=4, MODULUS=10, SATURATE=0: release reset, hold E=1, U=1 for 12 clks -> S = 0,1,…,9,0,1,2. TC high while S=9. OV high for exactly the one cycle after S 9->0.
- Same configuration, U=0 starting from S=0 -> S 0->9->8. TC high at S=0. OV pulses once after the 0->9 transition.
- SATURATE=1: count up to 9 and hold E=1 for 3 more clks -> S stays 9 and OV is high for 3 cycles. Set U=0 -> S = 8 and OV = 0.
- Load: L=1, D=5 -> S=5 next clk. L=1, D=13 -> S=9 (clamped). L=1 with E=1 and U=1 at S=9 -> S=D and OV=0.
- Mid-operation reset: counting up at S=6, drive reset low for 1 clk with E=1 and L=1 -> S=0, OV=0. Counting resumes 1,2,… after reset returns high.
- Edge parameters: WIDTH=2, MODULUS=4 (full range) and WIDTH=1, MODULUS=2 -> wrap and saturate behaviour as above. No out-of-range S appears.

Source files
------------

// File: rtl/fsm_counter.sv
// Parametrised modulo-MODULUS up/down counter with synchronous load, wrap or
// saturate at the range ends, a combinational terminal-count flag and a registered overflow pulse.
module fsm_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E,
  input  logic             U,
  input  logic             L,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] S,
  output logic             TC,
  output logic             OV
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("fsm_counter: WIDTH must be in 1..16");
  end
  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("fsm_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] LAST     = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is still representable.
  localparam logic [WIDTH:0]   LOAD_LIM = (WIDTH + 1)'(MODULUS);

  logic             at_top;
  logic             at_bottom;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH-1:0] load_val;

  assign at_top    = (S == LAST);
  assign at_bottom = (S == '0);
  assign d_ext     = {1'b0, D};
  assign load_val  = (d_ext >= LOAD_LIM) ? LAST : D;

  assign TC = E & ((U & at_top) | (~U & at_bottom));

  // NOTE: state is updated only with non-blocking assignments so every
  // branch sees the pre-edge value of S regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      S  <= '0;
      OV <= 1'b0;
    end else if (L) begin
      S  <= load_val;
      OV <= 1'b0;
    end else if (E) begin
      if (U) begin
        if (at_top) begin
          OV <= 1'b1;
          if (!SATURATE) S <= '0;
        end else begin
          S  <= S + WIDTH'(1);
          OV <= 1'b0;
        end
      end else begin
        if (at_bottom) begin
          OV <= 1'b1;
          if (!SATURATE) S <= LAST;
        end else begin
          S  <= S - WIDTH'(1);
          OV <= 1'b0;
        end
      end
    end else begin
      OV <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fsm_counter.sv
// Drives six fsm_counter configurations (wrap/saturate at WIDTH 4, 2, 1) with shared
// directed then random stimulus and compares each against an arithmetic reference model.
module tb_fsm_counter;

  localparam int N = 6;
  localparam int WS [N] = '{4, 4, 2, 2, 1, 1};
  localparam int MS [N] = '{10, 10, 4, 4, 2, 2};
  localparam bit SS [N] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        reset, e, u, l;
  logic [15:0] d;
  logic [15:0] obs_s [N];
  logic [N-1:0] obs_tc, obs_ov;

  int checks = 0;
  int errors = 0;
  int ms  [N];
  int mov [N];
  int ov_pulses;

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    localparam int W = WS[k];
    logic [W-1:0] s;
    fsm_counter #(.WIDTH(W), .MODULUS(MS[k]), .SATURATE(SS[k])) u_dut (
      .clk(clk), .reset(reset), .E(e), .U(u), .L(l), .D(d[W-1:0]),
      .S(s), .TC(obs_tc[k]), .OV(obs_ov[k])
    );
    assign obs_s[k] = 16'(s);
  end

  task automatic check(input string tag, input int idx, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d t=%0t: observed %0d expected %0d", tag, idx, $time, obs, exp);
    end
  endtask

  // Reference: counting is arithmetic on an integer; leaving 0..M-1 is an overflow event.
  function automatic int model_tc(int k, int s);
    int nxt;
    if (!e) return 0;
    nxt = u ? s + 1 : s - 1;
    return (nxt < 0 || nxt >= MS[k]) ? 1 : 0;
  endfunction

  task automatic model_edge(int k);
    int dv, nxt;
    dv = int'(d) % (1 << WS[k]);
    if (!reset) begin
      ms[k] = 0; mov[k] = 0;
    end else if (l) begin
      ms[k] = (dv < MS[k]) ? dv : MS[k] - 1; mov[k] = 0;
    end else if (e) begin
      nxt = u ? ms[k] + 1 : ms[k] - 1;
      if (nxt < 0 || nxt >= MS[k]) begin
        mov[k] = 1;
        if (!SS[k]) ms[k] = (nxt + MS[k]) % MS[k];
      end else begin
        ms[k] = nxt; mov[k] = 0;
      end
    end else begin
      mov[k] = 0;
    end
  endtask

  // Apply inputs, check TC combinationally, clock once, check S and OV after the edge.
  task automatic step(input logic rst_v, input logic e_v, input logic u_v,
                      input logic l_v, input logic [15:0] d_v);
    reset = rst_v; e = e_v; u = u_v; l = l_v; d = d_v;
    #1;
    for (int k = 0; k < N; k++) check("tc", k, 16'(obs_tc[k]), 16'(model_tc(k, ms[k])));
    @(posedge clk);
    for (int k = 0; k < N; k++) model_edge(k);
    #1;
    for (int k = 0; k < N; k++) begin
      check("s", k, obs_s[k], 16'(ms[k]));
      check("ov", k, 16'(obs_ov[k]), 16'(mov[k]));
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin ms[k] = 0; mov[k] = 0; end
    reset = 1'b0; e = 1'b0; u = 1'b0; l = 1'b0; d = '0;
    @(posedge clk); #1;

    // Reset wins over load and enable
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'd7);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check("reset_tc_idle", 0, 16'(obs_tc[0]), 16'd0);

    // Up count for 12 clocks from 0; dut0 walks 1..9,0,1,2
    ov_pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
      if (obs_ov[0]) ov_pulses++;
    end
    check("up12_s", 0, obs_s[0], 16'd2);
    check("up12_ov_pulses", 0, 16'(ov_pulses), 16'd1);
    check("up12_sat_s", 1, obs_s[1], 16'd9);

    // Down from 0: 0 -> 9 -> 8
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    check("down_wrap_s", 0, obs_s[0], 16'd9);
    check("down_wrap_ov", 0, 16'(obs_ov[0]), 16'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    check("down_s", 0, obs_s[0], 16'd8);

    // Saturate: load end of range, hold up-enable for 3 edges, then reverse
    step(1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
      check("sat_hold_ov", 1, 16'(obs_ov[1]), 16'd1);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    check("sat_rev_s", 1, obs_s[1], 16'd8);
    check("sat_rev_ov", 1, 16'(obs_ov[1]), 16'd0);

    // Loads: in range, clamped, and load beating an end-of-range enable
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'd5);
    check("load5", 0, obs_s[0], 16'd5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'd13);
    check("load13_clamp", 0, obs_s[0], 16'd9);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'd4);
    check("load_vs_en_s", 0, obs_s[0], 16'd4);
    check("load_vs_en_ov", 0, 16'(obs_ov[0]), 16'd0);

    // Mid-count reset with E and L asserted, then resume
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'd5);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'd3);
    check("midreset_s", 0, obs_s[0], 16'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'd0);
    check("resume_s", 0, obs_s[0], 16'd2);

    // A reset pulse entirely between edges must be ignored
    reset = 1'b0; #2; reset = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
    check("glitch_reset_s", 0, obs_s[0], 16'd2);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom), ($urandom_range(0, 9) == 0), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
